// File: rtl/serial_adder_sub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, one bit per clock, LSB
// first. Subtraction is a + ~b + 1, so cout=1 means no borrow.

// Single-bit full-adder cell used by the serial datapath.
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (b_i & c_i) | (a_i & c_i);

endmodule

module serial_adder_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // One extra bit so the counter never wraps before WIDTH bits are processed.
  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] sum_sh_next;

  full_adder_cell u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign sum_sh_next = {fa_s, sum_sh_q[WIDTH-1:1]};

  // Next-state and datapath updates for the IDLE/SHIFT sequencer.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        sum_sh_d = sum_sh_next;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_c;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          // Results are only exposed here so a partial sum is never visible.
          sum_d   = sum_sh_next;
          cout_d  = fa_c;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == StShift);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_sub.sv
// Randomized and directed checks of serial_adder_sub against an arithmetic reference model.
module tb_serial_adder_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_vec = 0;
  int n_err = 0;

  serial_adder_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: {cout, sum} from plain integer arithmetic.
  function automatic logic [W:0] ref_model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                           input logic tcin, input logic tsub);
    int unsigned ia, ib, full;
    ia = int'(ta);
    ib = int'(tb);
    if (tsub) begin
      full = (ia - ib) % (1 << W);
      return {(ia >= ib) ? 1'b1 : 1'b0, full[W-1:0]};
    end
    full = ia + ib + (tcin ? 1 : 0);
    return full[W:0];
  endfunction

  // Apply operands with start for one edge, then scramble the inputs.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input logic tsub);
    @(negedge clk);
    a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  // Wait for done, checking the old result stays held meanwhile; lat=0 on timeout.
  task automatic await_done(input logic [W:0] held, output int lat);
    lat = 0;
    for (int i = 1; i <= W + 4; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      check_eq("held_result", {cout, sum}, held);
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input logic tsub);
    logic [W:0] exp;
    logic [W:0] held;
    int lat;
    exp  = ref_model(ta, tb, tcin, tsub);
    held = {cout, sum};
    launch(ta, tb, tcin, tsub);
    check_eq({tag, "_busy"}, busy, 1'b1);
    await_done(held, lat);
    check_eq({tag, "_latency"}, lat, W);
    check_eq({tag, "_result"}, {cout, sum}, exp);
    check_eq({tag, "_busy_end"}, busy, 1'b0);
    @(posedge clk);
    #1;
    check_eq({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int n_done;
    logic [W:0] held;

    #2;
    check_eq("rst_sum", sum, '0);
    check_eq("rst_cout", cout, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("zero", 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("add_a5_5a", 8'hA5, 8'h5A, 1'b1, 1'b0);
    run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1);
    run_op("sub_01_02", 8'h01, 8'h02, 1'b0, 1'b1);
    run_op("sub_cin", 8'h05, 8'h05, 1'b1, 1'b1);

    // start while busy is ignored
    held = {cout, sum};
    launch(8'h03, 8'h04, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    await_done(held, lat);
    check_eq("ignore_latency", 3 + lat, W);
    check_eq("ignore_result", {cout, sum}, {1'b0, 8'h07});
    n_done = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check_eq("ignore_single_done", n_done, 0);

    // reset mid-operation
    launch(8'h80, 8'h80, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_sum", sum, '0);
    check_eq("abort_cout", cout, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) n_done++;
    end
    check_eq("abort_quiet", n_done, 0);
    run_op("after_abort", 8'h12, 8'h34, 1'b0, 1'b0);

    // start held through the done cycle: back-to-back operations
    held = {cout, sum};
    @(negedge clk);
    a = 8'h20; b = 8'h03; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'h01; b = 8'h01;
    await_done(held, lat);
    check_eq("b2b_first_latency", lat, W);
    check_eq("b2b_first_result", {cout, sum}, {1'b0, 8'h23});
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("b2b_restart_busy", busy, 1'b1);
    check_eq("b2b_done_low", done, 1'b0);
    await_done({1'b0, 8'h23}, lat);
    check_eq("b2b_second_latency", lat, W);
    check_eq("b2b_second_result", {cout, sum}, {1'b0, 8'h02});

    for (int i = 0; i < 40; i++) begin
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
